lut_prog_table: RTL and testbench

//  Programmable successor to the fixed pointer/immediate lookup table.
//  - Holds DEPTH entries of DW bits, indexed by an AW-bit pointer from the decoder.
//  - Entries load from a package default image after reset or on request; they are rewritable at run time.
//  - Registered read port: 1-cycle latency, zero/sign-extension to OW bits. Feeds dm_adr / immediate muxes.

---
 rtl/lut_prog_table_pkg.sv | 40 ++++
 rtl/lut_prog_table_init_seq.sv | 68 ++++++
 rtl/lut_prog_table.sv | 131 +++++++++++++
 tb/tb_lut_prog_table.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lut_prog_table_pkg.sv
// lut_pkg: shared types, default image and extension helper.
// Used by lut_prog_table (optional LUT_FWD_EN).
package lut_pkg;

  typedef enum logic {
    INIT = 1'b0,
    IDLE = 1'b1
  } lut_state_t;

  localparam int IMG_DEPTH = 32;
  localparam int IMG_W     = 8;
  localparam int EXT_W     = 64;

  localparam logic [IMG_W-1:0] DEFAULT_IMG [IMG_DEPTH] = '{
    8'hF5, 8'h09, 8'hEC, 8'h00, 8'h0F, 8'h05, 8'h00, 8'h00,
    8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00,
    8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00,
    8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00
  };

  // Widen a dw-bit entry, filling the upper bits with its msb or zero.
  function automatic logic [EXT_W-1:0] ext_entry(
    input logic [EXT_W-1:0] data,
    input int               dw,
    input logic             sext
  );
    logic [EXT_W-1:0] r;
    logic             msb;
    r   = '0;
    msb = 1'b0;
    for (int i = 0; i < EXT_W; i++) begin
      if (i == dw - 1) msb = data[i];
    end
    for (int i = 0; i < EXT_W; i++) begin
      r[i] = (i < dw) ? data[i] : (sext & msb);
    end
    return r;
  endfunction

endpackage

// File: rtl/lut_prog_table_init_seq.sv
// lut_init_seq: INIT/IDLE sequencer that streams the default
// image into the table after reset or on reinit.
module lut_init_seq
  import lut_pkg::*;
#(
  parameter int DW    = 8,
  parameter int AW    = 5,
  parameter int DEPTH = 32
) (
  input  logic          CLK,
  input  logic          reset_n,
  input  logic          reinit_i,
  output logic          busy_o,
  output logic          init_we_o,
  output logic [AW-1:0] init_addr_o,
  output logic [DW-1:0] init_data_o
);

  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

  lut_state_t    state_q, state_d;
  logic [AW-1:0] cnt_q, cnt_d;

  // State and init counter registers.
  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= INIT;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Walk every entry once in INIT, then wait for a reinit pulse.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      INIT: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      end
      IDLE: begin
        if (reinit_i) begin
          state_d = INIT;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = INIT;
        cnt_d   = '0;
      end
    endcase
  end

  // Init write port: one image entry per INIT cycle.
  always_comb begin
    busy_o      = (state_q == INIT);
    init_we_o   = busy_o;
    init_addr_o = cnt_q;
    init_data_o = DW'($signed(DEFAULT_IMG[cnt_q]));
  end

endmodule

// File: rtl/lut_prog_table.sv
// lut_prog_table: programmable pointer/immediate table with
// registered read. LUT_FWD_EN forwards same-cycle write data.
module lut_prog_table
  import lut_pkg::*;
#(
  parameter int DW    = 8,
  parameter int AW    = 5,
  parameter int DEPTH = 32,
  parameter int OW    = 8
) (
  input  logic          CLK,
  input  logic          reset_n,
  input  logic          reinit_i,
  input  logic          rd_en_i,
  input  logic [AW-1:0] rd_ptr_i,
  input  logic          sext_i,
  input  logic          wr_en_i,
  input  logic [AW-1:0] wr_ptr_i,
  input  logic [DW-1:0] wr_data_i,
  output logic          busy_o,
  output logic          rd_valid_o,
  output logic [OW-1:0] rd_data_o,
  output logic          oob_o
);

  localparam int        AW1     = AW + 1;
  localparam logic [AW:0] DEPTH_L = AW1'(DEPTH);

  logic          busy;
  logic          init_we;
  logic [AW-1:0] init_addr;
  logic [DW-1:0] init_data;

  logic [DW-1:0] mem_q [DEPTH];
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;

  logic          rd_fire, wr_fire;
  logic          rd_in, wr_in;
  logic [DW-1:0] rd_raw;
  logic [OW-1:0] rd_ext;

  logic          rd_valid_q, rd_valid_d;
  logic [OW-1:0] rd_data_q, rd_data_d;
  logic          oob_q, oob_d;

  lut_init_seq #(
    .DW    (DW),
    .AW    (AW),
    .DEPTH (DEPTH)
  ) u_init_seq (
    .CLK         (CLK),
    .reset_n     (reset_n),
    .reinit_i    (reinit_i),
    .busy_o      (busy),
    .init_we_o   (init_we),
    .init_addr_o (init_addr),
    .init_data_o (init_data)
  );

  // Request qualification: reinit and busy both swallow requests.
  always_comb begin
    rd_fire = rd_en_i & ~busy & ~reinit_i;
    wr_fire = wr_en_i & ~busy & ~reinit_i;
    rd_in   = ({1'b0, rd_ptr_i} < DEPTH_L);
    wr_in   = ({1'b0, wr_ptr_i} < DEPTH_L);
  end

  // Write arbitration: the init sequencer owns the port while busy.
  always_comb begin
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (init_we) begin
      mem_we    = 1'b1;
      mem_addr  = init_addr;
      mem_wdata = init_data;
    end else if (wr_fire && wr_in) begin
      mem_we    = 1'b1;
      mem_addr  = wr_ptr_i;
      mem_wdata = wr_data_i;
    end
  end

  // Table storage; contents come from the init sequencer, not reset.
  always_ff @(posedge CLK) begin
    if (mem_we) mem_q[mem_addr] <= mem_wdata;
  end

  // Read mux, optional write forwarding, and extension.
  always_comb begin
    rd_raw = rd_in ? mem_q[rd_ptr_i] : '0;
`ifdef LUT_FWD_EN
    if (rd_in && wr_fire && (wr_ptr_i == rd_ptr_i)) rd_raw = wr_data_i;
`else
    rd_raw = rd_raw;
`endif
    rd_ext = OW'(ext_entry(EXT_W'(rd_raw), DW, sext_i));
  end

  // Next output state: data and oob hold between reads.
  always_comb begin
    rd_valid_d = rd_fire;
    rd_data_d  = rd_data_q;
    oob_d      = oob_q;
    if (rd_fire) begin
      rd_data_d = rd_in ? rd_ext : '0;
      oob_d     = ~rd_in;
    end
  end

  // Output register.
  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
      oob_q      <= 1'b0;
    end else begin
      rd_valid_q <= rd_valid_d;
      rd_data_q  <= rd_data_d;
      oob_q      <= oob_d;
    end
  end

  assign busy_o     = busy;
  assign rd_valid_o = rd_valid_q;
  assign rd_data_o  = rd_data_q;
  assign oob_o      = oob_q;

endmodule

// File: tb/tb_lut_prog_table.sv
// tb_lut_prog_table: vectors, directed corners and a random
// model check for lut_prog_table (honours LUT_FWD_EN).
module tb_lut_prog_table;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic       reset_n;
  logic       reinit, rd_en, sext, wr_en;
  logic [4:0] rd_ptr, wr_ptr;
  logic [7:0] wr_data;

  logic        busy_a, rv_a, oob_a;
  logic [7:0]  rd_a;
  logic        busy_w, rv_w, oob_w;
  logic [15:0] rd_w;

  logic       d_reinit, d_rd_en, d_wr_en;
  logic [4:0] d_rd_ptr, d_wr_ptr;
  logic [7:0] d_wr_data;
  logic       busy_d, rv_d, oob_d;
  logic [7:0] rd_d;

  lut_prog_table dut_a (
    .CLK(CLK), .reset_n(reset_n), .reinit_i(reinit),
    .rd_en_i(rd_en), .rd_ptr_i(rd_ptr), .sext_i(sext),
    .wr_en_i(wr_en), .wr_ptr_i(wr_ptr), .wr_data_i(wr_data),
    .busy_o(busy_a), .rd_valid_o(rv_a), .rd_data_o(rd_a),
    .oob_o(oob_a)
  );

  lut_prog_table #(.OW(16)) dut_w (
    .CLK(CLK), .reset_n(reset_n), .reinit_i(reinit),
    .rd_en_i(rd_en), .rd_ptr_i(rd_ptr), .sext_i(sext),
    .wr_en_i(wr_en), .wr_ptr_i(wr_ptr), .wr_data_i(wr_data),
    .busy_o(busy_w), .rd_valid_o(rv_w), .rd_data_o(rd_w),
    .oob_o(oob_w)
  );

  lut_prog_table #(.DEPTH(24)) dut_d (
    .CLK(CLK), .reset_n(reset_n), .reinit_i(d_reinit),
    .rd_en_i(d_rd_en), .rd_ptr_i(d_rd_ptr), .sext_i(1'b1),
    .wr_en_i(d_wr_en), .wr_ptr_i(d_wr_ptr),
    .wr_data_i(d_wr_data),
    .busy_o(busy_d), .rd_valid_o(rv_d), .rd_data_o(rd_d),
    .oob_o(oob_d)
  );

  int n_run  = 0;
  int n_fail = 0;

  typedef struct {
    logic [4:0]  ptr;
    logic        s;
    logic [7:0]  e8;
    logic [15:0] e16;
  } rvec_t;

  rvec_t      tv [10];
  logic [7:0] bm [32];
  logic [7:0]  last8;
  logic [15:0] last16;
  int rv_seen;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h", nm, act, exp);
    end
  endtask

  function automatic logic [7:0] img(input int i);
    case (i)
      0: return 8'hF5;
      1: return 8'h09;
      2: return 8'hEC;
      4: return 8'h0F;
      5: return 8'h05;
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic [15:0] ext16(input logic [7:0] d,
                                        input logic s);
    return s ? 16'($signed(d)) : {8'h00, d};
  endfunction

  function automatic logic fwd_on();
`ifdef LUT_FWD_EN
    return 1'b1;
`else
    return 1'b0;
`endif
  endfunction

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle();
    reinit = 0; rd_en = 0; wr_en = 0;
    d_reinit = 0; d_rd_en = 0; d_wr_en = 0;
  endtask

  // Count cycles with busy high, bounded; tallies any rd_valid seen.
  task automatic wait_busy(output int ca, output int cd);
    ca = 0;
    cd = 0;
    for (int k = 0; k < 100 && (busy_a || busy_d); k++) begin
      if (busy_a) ca++;
      if (busy_d) cd++;
      step();
      if (rv_a) rv_seen++;
    end
  endtask

  task automatic rd_a8(input logic [4:0] p, input logic s,
                       input logic [7:0] e, input string nm);
    rd_en = 1; rd_ptr = p; sext = s;
    step();
    rd_en = 0;
    chk({nm, "_v"}, rv_a, 1);
    chk(nm, rd_a, e);
    chk({nm, "_w"}, rd_w, ext16(e, s));
  endtask

  task automatic rd_d8(input logic [4:0] p, input logic [7:0] e,
                       input logic eo, input string nm);
    d_rd_en = 1; d_rd_ptr = p;
    step();
    d_rd_en = 0;
    chk({nm, "_v"}, rv_d, 1);
    chk(nm, rd_d, e);
    chk({nm, "_oob"}, oob_d, eo);
  endtask

  initial begin
    int ca, cd;
    logic r, w, s;
    logic [4:0] rp, wp;
    logic [7:0] wd, e8;

    tv[0] = '{5'd0,  1'b1, 8'hF5, 16'hFFF5};
    tv[1] = '{5'd1,  1'b1, 8'h09, 16'h0009};
    tv[2] = '{5'd2,  1'b1, 8'hEC, 16'hFFEC};
    tv[3] = '{5'd3,  1'b1, 8'h00, 16'h0000};
    tv[4] = '{5'd4,  1'b1, 8'h0F, 16'h000F};
    tv[5] = '{5'd5,  1'b1, 8'h05, 16'h0005};
    tv[6] = '{5'd10, 1'b1, 8'h00, 16'h0000};
    tv[7] = '{5'd0,  1'b0, 8'hF5, 16'h00F5};
    tv[8] = '{5'd31, 1'b0, 8'h00, 16'h0000};
    tv[9] = '{5'd2,  1'b0, 8'hEC, 16'h00EC};

    reset_n = 0;
    idle();
    sext = 0; rd_ptr = 0; wr_ptr = 0; wr_data = 0;
    d_rd_ptr = 0; d_wr_ptr = 0; d_wr_data = 0;
    rv_seen = 0;
    #12;
    chk("rst_busy", busy_a, 1);
    chk("rst_valid", rv_a, 0);
    chk("rst_data", rd_a, 0);
    chk("rst_oob", oob_a, 0);
    chk("rst_busy_d", busy_d, 1);

    reset_n = 1;
    wait_busy(ca, cd);
    chk("init_cycles", ca, 32);
    chk("init_cycles_d24", cd, 24);
    chk("init_busy_w", busy_w, 0);

    for (int i = 0; i < 10; i++) begin
      rd_en = 1; rd_ptr = tv[i].ptr; sext = tv[i].s;
      step();
      chk("vec_valid", rv_a, 1);
      chk("vec_rd8", rd_a, tv[i].e8);
      chk("vec_rd16", rd_w, tv[i].e16);
      chk("vec_oob", oob_a, 0);
    end
    rd_en = 0;
    step();
    chk("noread_valid", rv_a, 0);
    chk("noread_hold", rd_a, 8'hEC);
    chk("noread_hold_w", rd_w, 16'h00EC);

    rd_d8(5'd0, 8'hF5, 0, "d24_rd0");
    rd_d8(5'd30, 8'h00, 1, "d24_rd30");
    step();
    chk("d24_hold_v", rv_d, 0);
    chk("d24_hold_oob", oob_d, 1);
    d_wr_en = 1; d_wr_ptr = 5'd30; d_wr_data = 8'h55;
    step();
    d_wr_en = 0;
    for (int i = 0; i < 24; i++)
      rd_d8(5'(i), img(i), 0, "d24_scan");
    rd_d8(5'd30, 8'h00, 1, "d24_rd30b");

    wr_en = 1; wr_ptr = 5'd7; wr_data = 8'h80;
    step();
    wr_en = 0;
    rd_a8(5'd7, 1'b0, 8'h80, "wr7");
    step();
    chk("wr7_pulse", rv_a, 0);
    chk("wr7_hold", rd_a, 8'h80);

    wr_en = 1; wr_ptr = 5'd1; wr_data = 8'h33;
    rd_en = 1; rd_ptr = 5'd1; sext = 1;
    step();
    idle();
    chk("same_valid", rv_a, 1);
    chk("same_data", rd_a, fwd_on() ? 8'h33 : 8'h09);
    rd_a8(5'd1, 1'b1, 8'h33, "after_same");

    wr_en = 1; wr_ptr = 5'd0; wr_data = 8'h5A;
    step();
    wr_en = 0;
    rd_a8(5'd0, 1'b1, 8'h5A, "ovw0");
    reinit = 1; wr_en = 1; wr_ptr = 0; wr_data = 8'h77;
    rd_en = 1; rd_ptr = 5'd3;
    step();
    chk("reinit_rd_drop", rv_a, 0);
    chk("reinit_busy", busy_a, 1);
    reinit = 0; wr_ptr = 5'd4; wr_data = 8'hAA;
    rv_seen = 0;
    wait_busy(ca, cd);
    idle();
    chk("reinit_cycles", ca, 32);
    chk("busy_rd_ignored", rv_seen, 0);
    rd_a8(5'd0, 1'b1, 8'hF5, "reinit_p0");
    rd_a8(5'd4, 1'b1, 8'h0F, "busy_wr_drop");
    rd_a8(5'd7, 1'b1, 8'h00, "reinit_p7");
    rd_a8(5'd1, 1'b1, 8'h09, "reinit_p1");

    for (int i = 0; i < 32; i++) bm[i] = img(i);
    last8 = 8'h09;
    last16 = 16'h0009;
    for (int it = 0; it < 300; it++) begin
      r  = 1'($urandom_range(0, 1));
      w  = 1'($urandom_range(0, 1));
      s  = 1'($urandom_range(0, 1));
      rp = 5'($urandom_range(0, 31));
      wp = ($urandom_range(0, 3) == 0) ? rp
           : 5'($urandom_range(0, 31));
      wd = 8'($urandom);
      rd_en = r; rd_ptr = rp; sext = s;
      wr_en = w; wr_ptr = wp; wr_data = wd;
      if ($urandom_range(0, 63) == 0) begin
        reinit = 1;
        step();
        idle();
        chk("rnd_reinit_drop", rv_a, 0);
        wait_busy(ca, cd);
        chk("rnd_reinit_cycles", ca, 32);
        for (int i = 0; i < 32; i++) bm[i] = img(i);
      end else begin
        step();
        if (r) begin
          e8 = (fwd_on() && w && wp == rp) ? wd : bm[rp];
          last8 = e8;
          last16 = ext16(e8, s);
        end
        chk("rnd_valid", rv_a, r);
        chk("rnd_rd8", rd_a, last8);
        chk("rnd_rd16", rd_w, last16);
        chk("rnd_oob", oob_a, 0);
        if (w) bm[wp] = wd;
      end
    end
    idle();

    rd_en = 1; rd_ptr = 5'd0; sext = 1;
    step();
    rd_en = 0;
    chk("mid_rd_valid", rv_a, 1);
    chk("mid_rd_data", rd_a, bm[0]);
    reset_n = 0;
    #1;
    chk("mid_rd_cancel", rv_a, 0);
    chk("mid_rd_clear", rd_a, 0);
    chk("mid_rd_busy", busy_a, 1);
    #2;
    reset_n = 1;
    repeat (10) step();
    reset_n = 0;
    #1;
    chk("mid_init_busy", busy_a, 1);
    #2;
    reset_n = 1;
    wait_busy(ca, cd);
    chk("mid_init_cycles", ca, 32);
    chk("mid_init_cycles_d24", cd, 24);
    rd_a8(5'd0, 1'b1, 8'hF5, "post_rst_p0");
    rd_a8(5'd2, 1'b1, 8'hEC, "post_rst_p2");
    rd_a8(5'd7, 1'b1, 8'h00, "post_rst_p7");

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
